// File: rtl/remote_pad_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | remote_pad_conditioner                                                     |
// | Synchronises and debounces the player-2 button lines from the slave board, |
// | emits rising-edge pulses and masks outputs during an opposing-direction    |
// | wiring fault.                                                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module remote_pad_conditioner #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int FAULT_CYCLES    = 2000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_BTN-1:0] raw_btn,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_rise,
   output logic             link_fault
);

   localparam int c_DW = $clog2(DEBOUNCE_CYCLES);
   localparam int c_FW = $clog2(FAULT_CYCLES);
   // The debounce counter is accepted on the edge where it would reach
   // DEBOUNCE_CYCLES-1; combined with the registered output stage this gives
   // a raw-to-output latency of exactly DEBOUNCE_CYCLES+2 edges.
   localparam logic [c_DW-1:0] c_DB_ACCEPT = c_DW'(DEBOUNCE_CYCLES - 2);
   localparam logic [c_DW-1:0] c_DB_ONE    = c_DW'(1);
   localparam logic [c_FW-1:0] c_F_LAST    = c_FW'(FAULT_CYCLES - 1);
   localparam logic [c_FW-1:0] c_F_ONE     = c_FW'(1);

   typedef enum logic [1:0] {
      ST_STABLE_LO = 2'd0,
      ST_CHK_HI    = 2'd1,
      ST_STABLE_HI = 2'd2,
      ST_CHK_LO    = 2'd3
   } db_state_t;

   typedef enum logic {
      F_OK    = 1'b0,
      F_FAULT = 1'b1
   } flt_state_t;

   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;
   logic [N_BTN-1:0] w_lvl;
   logic [N_BTN-1:0] w_lvl_nxt;
   logic [N_BTN-1:0] w_rise;
   logic [N_BTN-1:0] w_mask;

   flt_state_t       r_fst;
   flt_state_t       w_fst_nxt;
   logic [c_FW-1:0]  r_fcnt;
   logic [c_FW-1:0]  w_fcnt_nxt;
   logic             w_conflict;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= raw_btn;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      db_state_t       r_st;
      db_state_t       w_st_nxt;
      logic [c_DW-1:0] r_cnt;
      logic [c_DW-1:0] w_cnt_nxt;
      logic            w_acc;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_st  <= ST_STABLE_LO;
            r_cnt <= '0;
         end else begin
            r_st  <= w_st_nxt;
            r_cnt <= w_cnt_nxt;
         end
      end

      always_comb begin
         w_st_nxt  = r_st;
         w_cnt_nxt = r_cnt;
         w_acc     = 1'b0;
         case (r_st)
            ST_STABLE_LO: begin
               if (r_sync2[gi]) begin
                  w_st_nxt  = ST_CHK_HI;
                  w_cnt_nxt = '0;
               end
            end
            ST_CHK_HI: begin
               if (!r_sync2[gi]) begin
                  w_st_nxt = ST_STABLE_LO;
               end else if (r_cnt == c_DB_ACCEPT) begin
                  w_st_nxt = ST_STABLE_HI;
                  w_acc    = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + c_DB_ONE;
               end
            end
            ST_STABLE_HI: begin
               if (!r_sync2[gi]) begin
                  w_st_nxt  = ST_CHK_LO;
                  w_cnt_nxt = '0;
               end
            end
            ST_CHK_LO: begin
               if (r_sync2[gi]) begin
                  w_st_nxt = ST_STABLE_HI;
               end else if (r_cnt == c_DB_ACCEPT) begin
                  w_st_nxt = ST_STABLE_LO;
               end else begin
                  w_cnt_nxt = r_cnt + c_DB_ONE;
               end
            end
            default: w_st_nxt = ST_STABLE_LO;
         endcase
      end

      // The accepted level is implied by the state: high in STABLE_HI and
      // while a falling edge is still being qualified.
      assign w_lvl[gi]     = (r_st == ST_STABLE_HI) || (r_st == ST_CHK_LO);
      assign w_lvl_nxt[gi] = (w_st_nxt == ST_STABLE_HI) || (w_st_nxt == ST_CHK_LO);
      assign w_rise[gi]    = w_acc;
   end

   assign w_conflict = (w_lvl[0] & w_lvl[1]) | (w_lvl[2] & w_lvl[3]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fst  <= F_OK;
         r_fcnt <= '0;
      end else begin
         r_fst  <= w_fst_nxt;
         r_fcnt <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_fst_nxt  = r_fst;
      w_fcnt_nxt = '0;
      case (r_fst)
         F_OK: begin
            if (w_conflict) begin
               if (r_fcnt == c_F_LAST) begin
                  w_fst_nxt = F_FAULT;
               end else begin
                  w_fcnt_nxt = r_fcnt + c_F_ONE;
               end
            end
         end
         F_FAULT: begin
            if (!w_conflict) begin
               if (r_fcnt == c_F_LAST) begin
                  w_fst_nxt = F_OK;
               end else begin
                  w_fcnt_nxt = r_fcnt + c_F_ONE;
               end
            end
         end
         default: w_fst_nxt = F_OK;
      endcase
   end

   assign link_fault = (r_fst == F_FAULT);
   assign w_mask     = {N_BTN{enable & ~link_fault}};

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_level <= '0;
         btn_rise  <= '0;
      end else begin
         btn_level <= w_lvl_nxt & w_mask;
         btn_rise  <= w_rise & w_mask;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_remote_pad_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_remote_pad_conditioner                                                  |
// | Directed self-checking bench for remote_pad_conditioner (D=4, F=8).        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_remote_pad_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [4:0] raw_btn;
   logic [4:0] btn_level;
   logic [4:0] btn_rise;
   logic       link_fault;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   remote_pad_conditioner #(
      .N_BTN(5),
      .DEBOUNCE_CYCLES(4),
      .FAULT_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .raw_btn(raw_btn),
      .btn_level(btn_level),
      .btn_rise(btn_rise),
      .link_fault(link_fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      enable  = 1'b1;
      raw_btn = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (btn_level !== 5'b00000) begin bad++; $display("FAIL reset_level got=%b exp=%b", btn_level, 5'b00000); end
      total++; if (btn_rise !== 5'b00000) begin bad++; $display("FAIL reset_rise got=%b exp=%b", btn_rise, 5'b00000); end
      total++; if (link_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", link_fault); end
   endtask

   task automatic test_latency();
      do_reset();
      raw_btn = 5'b10000;
      for (int k = 1; k <= 5; k++) begin
         tick();
         total++; if (btn_level !== 5'b00000 || btn_rise !== 5'b00000) begin bad++; $display("FAIL lat_early edge=%0d level=%b rise=%b exp=00000", k, btn_level, btn_rise); end
      end
      tick();
      total++; if (btn_level !== 5'b10000) begin bad++; $display("FAIL lat_level got=%b exp=%b", btn_level, 5'b10000); end
      total++; if (btn_rise !== 5'b10000) begin bad++; $display("FAIL lat_rise got=%b exp=%b", btn_rise, 5'b10000); end
      tick();
      total++; if (btn_rise !== 5'b00000) begin bad++; $display("FAIL lat_rise_once got=%b exp=%b", btn_rise, 5'b00000); end
      total++; if (btn_level !== 5'b10000) begin bad++; $display("FAIL lat_level_hold got=%b exp=%b", btn_level, 5'b10000); end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int k = 0; k < 14; k++) begin
         raw_btn = (k < 3) ? 5'b00100 : 5'b00000;
         tick();
         total++; if (btn_level !== 5'b00000 || btn_rise !== 5'b00000) begin bad++; $display("FAIL glitch edge=%0d level=%b rise=%b exp=00000", k + 1, btn_level, btn_rise); end
      end
   endtask

   task automatic test_fault();
      do_reset();
      raw_btn = 5'b00011;
      repeat (6) tick();
      total++; if (btn_level !== 5'b00011) begin bad++; $display("FAIL flt_level got=%b exp=%b", btn_level, 5'b00011); end
      total++; if (btn_rise !== 5'b00011) begin bad++; $display("FAIL flt_rise got=%b exp=%b", btn_rise, 5'b00011); end
      repeat (7) tick();
      total++; if (link_fault !== 1'b0) begin bad++; $display("FAIL flt_early got=%b exp=0", link_fault); end
      tick();
      total++; if (link_fault !== 1'b1) begin bad++; $display("FAIL flt_set got=%b exp=1", link_fault); end
      total++; if (btn_level !== 5'b00011) begin bad++; $display("FAIL flt_mask_lag got=%b exp=%b", btn_level, 5'b00011); end
      tick();
      total++; if (btn_level !== 5'b00000) begin bad++; $display("FAIL flt_masked got=%b exp=%b", btn_level, 5'b00000); end
      raw_btn = 5'b00001;
      repeat (13) tick();
      total++; if (link_fault !== 1'b1) begin bad++; $display("FAIL flt_hold got=%b exp=1", link_fault); end
      tick();
      total++; if (link_fault !== 1'b0) begin bad++; $display("FAIL flt_clear got=%b exp=0", link_fault); end
      total++; if (btn_level !== 5'b00000) begin bad++; $display("FAIL flt_unmask_lag got=%b exp=%b", btn_level, 5'b00000); end
      tick();
      total++; if (btn_level !== 5'b00001) begin bad++; $display("FAIL flt_unmask_level got=%b exp=%b", btn_level, 5'b00001); end
      total++; if (btn_rise !== 5'b00000) begin bad++; $display("FAIL flt_unmask_rise got=%b exp=%b", btn_rise, 5'b00000); end
   endtask

   task automatic test_enable_mask();
      do_reset();
      enable  = 1'b0;
      raw_btn = 5'b00001;
      for (int k = 1; k <= 10; k++) begin
         tick();
         total++; if (btn_level !== 5'b00000 || btn_rise !== 5'b00000) begin bad++; $display("FAIL en_masked edge=%0d level=%b rise=%b exp=00000", k, btn_level, btn_rise); end
      end
      enable = 1'b1;
      tick();
      total++; if (btn_level !== 5'b00001) begin bad++; $display("FAIL en_level got=%b exp=%b", btn_level, 5'b00001); end
      total++; if (btn_rise !== 5'b00000) begin bad++; $display("FAIL en_no_rise got=%b exp=%b", btn_rise, 5'b00000); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      raw_btn = 5'b01000;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      total++; if (btn_level !== 5'b00000) begin bad++; $display("FAIL rmid_in_reset got=%b exp=%b", btn_level, 5'b00000); end
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         total++; if (btn_level !== 5'b00000 || btn_rise !== 5'b00000) begin bad++; $display("FAIL rmid_early edge=%0d level=%b rise=%b exp=00000", k, btn_level, btn_rise); end
      end
      tick();
      total++; if (btn_level !== 5'b01000) begin bad++; $display("FAIL rmid_level got=%b exp=%b", btn_level, 5'b01000); end
      total++; if (btn_rise !== 5'b01000) begin bad++; $display("FAIL rmid_rise got=%b exp=%b", btn_rise, 5'b01000); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      raw_btn = 5'b11000;
      repeat (6) tick();
      total++; if (btn_rise !== 5'b11000) begin bad++; $display("FAIL sim_rise got=%b exp=%b", btn_rise, 5'b11000); end
      total++; if (btn_level !== 5'b11000) begin bad++; $display("FAIL sim_level got=%b exp=%b", btn_level, 5'b11000); end
      for (int k = 1; k <= 12; k++) begin
         tick();
         total++; if (link_fault !== 1'b0) begin bad++; $display("FAIL sim_no_fault edge=%0d got=%b exp=0", k, link_fault); end
      end
      total++; if (btn_level !== 5'b11000 || btn_rise !== 5'b00000) begin bad++; $display("FAIL sim_hold level=%b rise=%b exp=11000/00000", btn_level, btn_rise); end
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b1;
      raw_btn = '0;
      test_reset();
      test_latency();
      test_glitch();
      test_fault();
      test_enable_mask();
      test_reset_mid();
      test_simultaneous();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
